awg_sample_buffer: RTL and testbench
====================================

Name: awg_sample_buffer

Overview:
- Arbitrary-waveform source that sits directly upstream of the R2R DAC output stage, as an alternative to the sine lookup.
- Samples are loaded byte-by-byte from the ui_in data pins into a small RAM, then replayed cyclically at a programmable rate.
- It presents sample[7:0] to the DAC control mux plus a per-sample strobe and a wrap strobe for scope triggering.

Parameters:
- DEPTH, 32, number of 8-bit sample slots; power of 2, range 4..64.
- AW, $clog2(DEPTH), address width; derived, do not override.

Ports:
- clk  in  1  system clock (10 MHz nominal).
- n_rst  in  1  reset: n_rst, asynchronous, active-high; clock clk.
- wr_en  in  1  write strobe: store wr_data at the next free slot.
- wr_data  in  8  sample byte to store.
- wr_clear  in  1  empty the buffer (length <= 0).
- run  in  1  level: 1 = play back, 0 = idle/load.
- divider  in  8  sample period = divider+1 clk cycles.
- sample  out  8  current sample to DAC (registered).
- sample_stb  out  1  one-cycle pulse on the cycle sample updates.
- wrap  out  1  one-cycle pulse coincident with the sample_stb that outputs slot 0.
- length  out  AW+1  number of valid samples, 0..DEPTH.
- full  out  1  length == DEPTH.
- wr_err  out  1  one-cycle pulse: write rejected (full, or while playing).

Behaviour:
- Reset (async assert, n_rst high): state IDLE; sample=0, sample_stb=0, wrap=0, length=0, full=0, wr_err=0; rd_ptr=0, cnt=0.
- RAM contents are not reset; reads of unwritten slots are never issued because rd_ptr < length always holds.
- States: IDLE, PLAY (2-state FSM, registered).
- IDLE:
  - wr_clear=1 -> length<=0; has priority over wr_en in the same cycle, and that write is dropped without wr_err.
  - wr_en=1 and not full -> mem[length]<=wr_data, length<=length+1.
  - wr_en=1 and full -> no write, wr_err=1 next cycle.
  - run=1 and length!=0 -> PLAY; rd_ptr<=0, cnt<=0. A write in the same cycle still completes and is included in playback.
  - run=1 and length==0 -> stay IDLE; sample holds.
- PLAY, evaluated each clk edge:
  - cnt==0 -> sample<=mem[rd_ptr], sample_stb<=1, wrap<=(rd_ptr==0), cnt<=divider, and rd_ptr<=(rd_ptr==length-1)?0:rd_ptr+1.
  - cnt!=0 -> cnt<=cnt-1; sample_stb<=0, wrap<=0.
- Latency: PLAY entered at edge k; first sample (slot 0) registered at edge k+1; subsequent samples every divider+1 cycles.
- divider=0 -> new sample every cycle.
- divider changes mid-play take effect at the next reload; the current period is not truncated.
- Writes and wr_clear during PLAY are ignored; wr_en raises wr_err. length is frozen during PLAY.
- run=0 during PLAY -> IDLE at next edge. sample holds its last value. sample_stb/wrap go 0. rd_ptr, cnt reset to 0 on the next PLAY entry.
- length=1 -> the same sample re-issues every period, with wrap on every strobe.
- Reset mid-play -> immediate return to the reset values above; length=0, so the buffer is effectively discarded.
- Arithmetic: length is AW+1 bits so DEPTH is representable. rd_ptr and the write address use the low AW bits. cnt is 8 bits, unsigned.

Decomposition:
- Shared package (dac_pkg): state encoding localparams (ST_IDLE, ST_PLAY) and DEPTH_DEFAULT=32. The sine lookup and DAC control reuse the sample width constant SAMPLE_W=8.
- One sub-module: awg_sample_ram, a DEPTH x 8 memory:
  - synchronous write, asynchronous read;
  - ports: clk, we, waddr, wdata, raddr, rdata;
  - no reset.
- FSM, counters and pointers live in awg_sample_buffer.

Test Plan:
- Reset, then load 4 bytes 0x10,0x40,0x80,0xF0 -> length=4, full=0, no wr_err; sample=0.
- Same buffer, divider=2, run=1 at edge k:
  - sample = 0x10, 0x40, 0x80, 0xF0, 0x10 at edges k+1, k+4, k+7, k+10, k+13;
  - sample_stb high exactly at those edges;
  - wrap high at k+1 and k+13 only.
- Write 32 bytes (0..31), then a 33rd write of 0xAA -> full=1, length=32, wr_err pulses once; playback with divider=0 outputs 0..31 then 0, and 0xAA never appears.
- During PLAY, assert wr_en and wr_clear -> length unchanged, wr_err pulses for wr_en; playback sequence unaffected.
- divider changed from 5 to 1 mid-period -> the current period completes at 6 cycles, and the following periods are 2 cycles.
- Edge cases:
  - run=1 with length=0 -> stays IDLE, no sample_stb.
  - n_rst asserted mid-play -> sample=0 and length=0 asynchronously; after release with run=1, no playback until reloaded.

Source files
------------

// File: rtl/dac_pkg.sv
// Constants and state encoding shared by the DAC-side sample sources
// (sine lookup, arbitrary-waveform buffer, DAC control mux).
package dac_pkg;

    localparam int SAMPLE_W      = 8;
    localparam int DEPTH_DEFAULT = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } awg_state_t;

endpackage

// File: rtl/awg_sample_buffer_if.sv
// Load/playback bus of the arbitrary-waveform buffer. The master loads bytes
// and controls playback; the slave (the buffer) returns the sample stream.
interface awg_sample_buffer_if #(
    parameter int DEPTH = dac_pkg::DEPTH_DEFAULT
) ();
    localparam int AW = $clog2(DEPTH);

    logic                         wr_en;
    logic [dac_pkg::SAMPLE_W-1:0] wr_data;
    logic                         wr_clear;
    logic                         run;
    logic [7:0]                   divider;
    logic [dac_pkg::SAMPLE_W-1:0] sample;
    logic                         sample_stb;
    logic                         wrap;
    logic [AW:0]                  length;
    logic                         full;
    logic                         wr_err;

    modport master (
        output wr_en, wr_data, wr_clear, run, divider,
        input  sample, sample_stb, wrap, length, full, wr_err
    );

    modport slave (
        input  wr_en, wr_data, wr_clear, run, divider,
        output sample, sample_stb, wrap, length, full, wr_err
    );
endinterface

// File: rtl/awg_sample_ram.sv
// DEPTH x SAMPLE_W sample store: synchronous write, asynchronous read, no reset.
module awg_sample_ram import dac_pkg::*; #(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);
    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/awg_sample_buffer.sv
// Arbitrary-waveform source: bytes are appended in IDLE, then replayed
// cyclically in PLAY with one sample every divider+1 clocks.
module awg_sample_buffer import dac_pkg::*; #(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               n_rst,
    awg_sample_buffer_if.slave bus
);
    awg_state_t          state, state_nxt;
    logic [AW:0]         length;
    logic [AW-1:0]       rd_ptr;
    logic [7:0]          cnt;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_stb;
    logic                wrap;
    logic                wr_err;
    logic [SAMPLE_W-1:0] rdata;
    logic                full_w;

    logic do_write, do_clear, go_play, do_step, wr_rej;

    assign full_w = (length == (AW+1)'(DEPTH));

    // Write address is the current fill level; rd_ptr < length keeps reads
    // inside the written region.
    awg_sample_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr (length[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go_play)  state_nxt = ST_PLAY;
            ST_PLAY: if (!bus.run) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A clear in the same cycle as run would leave an empty buffer in PLAY,
    // so it blocks entry as well as the write.
    always_comb begin
        do_write = 1'b0;
        do_clear = 1'b0;
        go_play  = 1'b0;
        do_step  = 1'b0;
        wr_rej   = 1'b0;
        case (state)
            ST_IDLE: begin
                do_clear = bus.wr_clear;
                do_write = bus.wr_en && !bus.wr_clear && !full_w;
                wr_rej   = bus.wr_en && !bus.wr_clear &&  full_w;
                go_play  = bus.run && (length != '0) && !bus.wr_clear;
            end
            ST_PLAY: begin
                do_step  = bus.run && (cnt == 8'd0);
                wr_rej   = bus.wr_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            length     <= '0;
            rd_ptr     <= '0;
            cnt        <= 8'd0;
            sample     <= '0;
            sample_stb <= 1'b0;
            wrap       <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            wr_err     <= wr_rej;
            sample_stb <= do_step;
            wrap       <= do_step && (rd_ptr == '0);

            if (do_clear)      length <= '0;
            else if (do_write) length <= length + (AW+1)'(1);

            if (go_play) begin
                rd_ptr <= '0;
                cnt    <= 8'd0;
            end else if (state == ST_PLAY && bus.run) begin
                if (cnt == 8'd0) begin
                    sample <= rdata;
                    cnt    <= bus.divider;
                    rd_ptr <= ({1'b0, rd_ptr} == length - (AW+1)'(1)) ? '0
                                                                      : rd_ptr + AW'(1);
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
        end
    end

    assign bus.sample     = sample;
    assign bus.sample_stb = sample_stb;
    assign bus.wrap       = wrap;
    assign bus.length     = length;
    assign bus.full       = full_w;
    assign bus.wr_err     = wr_err;
endmodule

// File: tb/tb_awg_sample_buffer.sv
// Directed bench for awg_sample_buffer: load, cyclic playback, overflow,
// writes during play, divider change, empty-run and mid-play reset.
module tb_awg_sample_buffer;
    import dac_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    awg_sample_buffer_if #(.DEPTH(32)) bus ();

    awg_sample_buffer #(.DEPTH(32)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs changed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq4 [4];
        logic [7:0] exp_s;
        logic       stb_e;
        int         n_stb;

        seq4[0] = 8'h10; seq4[1] = 8'h40; seq4[2] = 8'h80; seq4[3] = 8'hF0;
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.wr_clear = 1'b0;
        bus.run = 1'b0; bus.divider = 8'd0;

        // reset
        tick(); tick();
        n_rst = 1'b0;
        tick();
        check("rst_sample", bus.sample, 32'h0);
        check("rst_stb",    bus.sample_stb, 32'h0);
        check("rst_wrap",   bus.wrap, 32'h0);
        check("rst_length", bus.length, 32'h0);
        check("rst_full",   bus.full, 32'h0);
        check("rst_wr_err", bus.wr_err, 32'h0);

        // load 4 bytes
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = seq4[i];
            tick();
            check("load4_wr_err", bus.wr_err, 32'h0);
        end
        bus.wr_en = 1'b0;
        check("load4_length", bus.length, 32'd4);
        check("load4_full",   bus.full, 32'h0);
        check("load4_sample", bus.sample, 32'h0);

        // play divider=2: strobes at k+1,4,7,10,13, wrap at k+1 and k+13
        bus.divider = 8'd2; bus.run = 1'b1;
        tick();
        check("play4_k_stb", bus.sample_stb, 32'h0);
        exp_s = 8'h00;
        for (int i = 1; i <= 13; i++) begin
            tick();
            stb_e = (i % 3 == 1);
            if (stb_e) exp_s = seq4[((i - 1) / 3) % 4];
            check("play4_stb",    bus.sample_stb, {31'h0, stb_e});
            check("play4_wrap",   bus.wrap, {31'h0, (i == 1 || i == 13)});
            check("play4_sample", bus.sample, {24'h0, exp_s});
        end
        bus.run = 1'b0;
        tick();
        check("stop_stb",    bus.sample_stb, 32'h0);
        check("stop_sample", bus.sample, 32'h10);

        // clear, then run on an empty buffer
        bus.wr_clear = 1'b1;
        tick();
        bus.wr_clear = 1'b0;
        check("clear_length", bus.length, 32'h0);
        bus.run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("empty_run_stb",    bus.sample_stb, 32'h0);
            check("empty_run_sample", bus.sample, 32'h10);
        end
        bus.run = 1'b0;
        tick();

        // fill 32, then overflow with 0xAA
        for (int i = 0; i < 32; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            tick();
        end
        check("fill_length", bus.length, 32'd32);
        check("fill_full",   bus.full, 32'h1);
        check("fill_wr_err", bus.wr_err, 32'h0);
        bus.wr_data = 8'hAA;
        tick();
        bus.wr_en = 1'b0;
        check("ovf_wr_err", bus.wr_err, 32'h1);
        check("ovf_length", bus.length, 32'd32);
        tick();
        check("ovf_wr_err_clr", bus.wr_err, 32'h0);

        // play divider=0: 0..31 then 0
        bus.divider = 8'd0; bus.run = 1'b1;
        tick();
        check("play32_k_stb", bus.sample_stb, 32'h0);
        for (int i = 0; i <= 32; i++) begin
            tick();
            check("play32_stb",    bus.sample_stb, 32'h1);
            check("play32_sample", bus.sample, 32'(i % 32));
            check("play32_wrap",   bus.wrap, {31'h0, (i % 32 == 0)});
        end

        // write and clear during play are ignored, write flags wr_err
        bus.wr_en = 1'b1; bus.wr_clear = 1'b1; bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0; bus.wr_clear = 1'b0;
        check("playwr_sample", bus.sample, 32'd1);
        check("playwr_wr_err", bus.wr_err, 32'h1);
        check("playwr_length", bus.length, 32'd32);
        tick();
        check("playwr_sample2", bus.sample, 32'd2);
        check("playwr_wr_err2", bus.wr_err, 32'h0);
        check("playwr_length2", bus.length, 32'd32);
        bus.run = 1'b0;
        tick();
        check("stop2_stb",    bus.sample_stb, 32'h0);
        check("stop2_sample", bus.sample, 32'd2);

        // divider 5 -> 1 mid-period: strobes at k+1, k+7, k+9, k+11
        bus.divider = 8'd5; bus.run = 1'b1;
        tick();
        exp_s = 8'd2; n_stb = 0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            stb_e = (i == 1 || i == 7 || i == 9 || i == 11);
            if (stb_e) begin
                exp_s = 8'(n_stb);
                n_stb++;
            end
            check("div_stb",    bus.sample_stb, {31'h0, stb_e});
            check("div_sample", bus.sample, {24'h0, exp_s});
            if (i == 3) bus.divider = 8'd1;
        end

        // asynchronous reset mid-play
        #2 n_rst = 1'b1;
        #1;
        check("arst_sample", bus.sample, 32'h0);
        check("arst_length", bus.length, 32'h0);
        check("arst_stb",    bus.sample_stb, 32'h0);
        check("arst_full",   bus.full, 32'h0);
        tick();
        n_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_stb",    bus.sample_stb, 32'h0);
            check("post_rst_length", bus.length, 32'h0);
        end
        bus.run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
